core_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the RV64 core datapath. It breaks each instruction into fetch, decode, execute, memory and writeback phases. It drives the request/ready handshakes to instruction and data memory, gates architectural writes (regfile, dmem, CSR, PC), and routes exceptions, memory timeouts and pending interrupts into a dedicated trap-commit cycle. It sits beside the decoder; its commit enables are ANDed with the decoder's raw we_regs/we_dmem/we_csr.

---
 rtl/core_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle phase sequencer for the RV64 core datapath.
// Each instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> WB. A
// dedicated TRAP cycle handles exceptions, memory timeouts and interrupts.
// Only the phase and the wait counter are stored. Every other output is
// decoded from the current phase and this cycle's inputs.
module core_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        is_LOAD,
  input  logic        is_STORE,
  input  logic        is_CSR,
  input  logic        mret,
  input  logic        exc_en,
  input  logic        irq_pending,
  input  logic [63:0] pc_addr,
  input  logic [63:0] dmem_addr,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        we_regs_en,
  output logic        we_csr_en,
  output logic        pc_en,
  output logic        instr_retired,
  output logic        trap_commit,
  output logic        to_exc_en,
  output logic [3:0]  to_exc_code,
  output logic [63:0] to_exc_val,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  // Exception codes raised when a memory request waits too long.
  localparam logic [3:0] CODE_INSTR_FAULT = 4'd1;
  localparam logic [3:0] CODE_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] CODE_STORE_FAULT = 4'd7;

  // Counter value seen on the last allowed waiting cycle.
  localparam int              TO_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_LAST_I);
  localparam logic             TO_ON    = (TIMEOUT_CYCLES != 0);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  logic in_wait;      // phase that has an outstanding memory request
  logic wait_ready;   // ready of whichever memory the current phase waits on
  logic timeout;      // this is the last waiting cycle and ready is still low

  // MRET needs no state of its own. The pc block selects the return address.
  logic unused_mret;
  assign unused_mret = mret;

  assign state = state_q;

  // Timeout detection for the memory request that is currently outstanding.
  always_comb begin
    in_wait    = (state_q == S_FETCH) || (state_q == S_MEM);
    wait_ready = (state_q == S_FETCH) ? imem_ready : dmem_ready;
    timeout    = TO_ON && in_wait && !wait_ready && (wait_cnt_q == TO_LAST);
  end

  // Next phase. Within a cycle exc_en beats ready, and ready beats timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (exc_en)          state_d = S_TRAP;
        else if (imem_ready) state_d = S_DECODE;
        else if (timeout)    state_d = S_TRAP;
        else                 state_d = S_FETCH;
      end
      S_DECODE: state_d = exc_en ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (exc_en)                  state_d = S_TRAP;
        else if (is_LOAD || is_STORE) state_d = S_MEM;
        else                         state_d = S_WB;
      end
      S_MEM: begin
        if (exc_en)          state_d = S_TRAP;
        else if (dmem_ready) state_d = S_WB;
        else if (timeout)    state_d = S_TRAP;
        else                 state_d = S_MEM;
      end
      S_WB: begin
        // An interrupt is taken only after the current instruction retires.
        if (exc_en || irq_pending) state_d = S_TRAP;
        else                       state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Wait counter: restarts whenever a fetch or data phase is entered,
  // counts waiting cycles, and saturates instead of wrapping.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (((state_d == S_FETCH) && (state_q != S_FETCH)) ||
        ((state_d == S_MEM)   && (state_q != S_MEM))) begin
      wait_cnt_d = '0;
    end else if (in_wait && !wait_ready && (wait_cnt_q != {CNT_W{1'b1}})) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Handshake, commit and trap outputs decoded from the phase and the inputs.
  always_comb begin
    imem_req      = 1'b0;
    ir_load       = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    we_regs_en    = 1'b0;
    we_csr_en     = 1'b0;
    pc_en         = 1'b0;
    instr_retired = 1'b0;
    trap_commit   = 1'b0;
    to_exc_en     = 1'b0;
    to_exc_code   = 4'd0;
    to_exc_val    = 64'd0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (!exc_en) begin
          if (imem_ready) begin
            ir_load = 1'b1;
          end else if (timeout) begin
            to_exc_en   = 1'b1;
            to_exc_code = CODE_INSTR_FAULT;
            to_exc_val  = pc_addr;
          end
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        // A faulting access must never reach memory as a write.
        dmem_we  = is_STORE && !exc_en;
        if (!exc_en && timeout) begin
          to_exc_en   = 1'b1;
          to_exc_code = is_STORE ? CODE_STORE_FAULT : CODE_LOAD_FAULT;
          to_exc_val  = dmem_addr;
        end
      end
      S_WB: begin
        // A late exception cancels the whole commit of this instruction.
        if (!exc_en) begin
          pc_en         = 1'b1;
          instr_retired = 1'b1;
          we_regs_en    = !is_STORE;
          we_csr_en     = is_CSR;
        end
      end
      S_TRAP: begin
        trap_commit = 1'b1;
        pc_en       = 1'b1;
      end
      default: ;
    endcase
  end

  // Phase and wait-counter registers. The reset is asynchronous, so an
  // outstanding request drops as soon as rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed testbench for core_seq_ctrl. A per-cycle vector table covers
// the main phase sequences. Hand-written loops cover timeouts and the
// asynchronous reset.
module tb_core_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_ready, dmem_ready, is_LOAD, is_STORE, is_CSR, mret;
  logic        exc_en, irq_pending;
  logic [63:0] pc_addr, dmem_addr;
  logic        imem_req, ir_load, dmem_req, dmem_we, we_regs_en, we_csr_en;
  logic        pc_en, instr_retired, trap_commit, to_exc_en;
  logic [3:0]  to_exc_code;
  logic [63:0] to_exc_val;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  core_seq_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .is_LOAD(is_LOAD), .is_STORE(is_STORE), .is_CSR(is_CSR), .mret(mret),
    .exc_en(exc_en), .irq_pending(irq_pending),
    .pc_addr(pc_addr), .dmem_addr(dmem_addr),
    .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .we_regs_en(we_regs_en), .we_csr_en(we_csr_en), .pc_en(pc_en),
    .instr_retired(instr_retired), .trap_commit(trap_commit),
    .to_exc_en(to_exc_en), .to_exc_code(to_exc_code), .to_exc_val(to_exc_val),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input bits: {imem_ready, dmem_ready, is_LOAD, is_STORE, is_CSR, exc_en, irq_pending}
  localparam logic [6:0] I_IR  = 7'b1000000;
  localparam logic [6:0] I_DR  = 7'b0100000;
  localparam logic [6:0] I_LD  = 7'b0010000;
  localparam logic [6:0] I_ST  = 7'b0001000;
  localparam logic [6:0] I_CSR = 7'b0000100;
  localparam logic [6:0] I_EXC = 7'b0000010;
  localparam logic [6:0] I_IRQ = 7'b0000001;
  localparam logic [6:0] I_0   = 7'b0000000;

  // Output bits: {imem_req, ir_load, dmem_req, dmem_we, we_regs_en,
  //               we_csr_en, pc_en, instr_retired, trap_commit, to_exc_en}
  localparam logic [9:0] O_IREQ = 10'b1000000000;
  localparam logic [9:0] O_IRL  = 10'b0100000000;
  localparam logic [9:0] O_DREQ = 10'b0010000000;
  localparam logic [9:0] O_DWE  = 10'b0001000000;
  localparam logic [9:0] O_WREG = 10'b0000100000;
  localparam logic [9:0] O_WCSR = 10'b0000010000;
  localparam logic [9:0] O_PC   = 10'b0000001000;
  localparam logic [9:0] O_RET  = 10'b0000000100;
  localparam logic [9:0] O_TRAP = 10'b0000000010;
  localparam logic [9:0] O_0    = 10'b0000000000;

  typedef struct {
    logic [6:0] in;
    logic [2:0] st;
    logic [9:0] out;
  } vec_t;

  localparam int NV = 44;
  vec_t vecs [NV];

  function automatic logic [9:0] outs_now();
    return {imem_req, ir_load, dmem_req, dmem_we, we_regs_en,
            we_csr_en, pc_en, instr_retired, trap_commit, to_exc_en};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then wait for the falling edge to sample.
  task automatic apply(input logic [6:0] v);
    {imem_ready, dmem_ready, is_LOAD, is_STORE, is_CSR, exc_en, irq_pending} = v;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int i, input logic [6:0] in, input logic [2:0] st, input logic [9:0] out);
    vecs[i].in  = in;
    vecs[i].st  = st;
    vecs[i].out = out;
  endtask

  initial begin
    // ALU instruction twice, back to back.
    setv(0,  I_IR, 3'd0, O_0);
    setv(1,  I_IR, 3'd1, O_IREQ | O_IRL);
    setv(2,  I_IR, 3'd2, O_0);
    setv(3,  I_IR, 3'd3, O_0);
    setv(4,  I_IR, 3'd5, O_WREG | O_PC | O_RET);
    setv(5,  I_IR, 3'd1, O_IREQ | O_IRL);
    setv(6,  I_IR, 3'd2, O_0);
    setv(7,  I_IR, 3'd3, O_0);
    setv(8,  I_IR, 3'd5, O_WREG | O_PC | O_RET);
    // Load whose dmem_ready arrives 3 cycles late.
    setv(9,  I_IR, 3'd1, O_IREQ | O_IRL);
    setv(10, I_LD, 3'd2, O_0);
    setv(11, I_LD, 3'd3, O_0);
    setv(12, I_LD, 3'd4, O_DREQ);
    setv(13, I_LD, 3'd4, O_DREQ);
    setv(14, I_LD, 3'd4, O_DREQ);
    setv(15, I_LD | I_DR, 3'd4, O_DREQ);
    setv(16, I_LD, 3'd5, O_WREG | O_PC | O_RET);
    // Illegal instruction detected in DECODE.
    setv(17, I_IR, 3'd1, O_IREQ | O_IRL);
    setv(18, I_EXC, 3'd2, O_0);
    setv(19, I_0, 3'd6, O_TRAP | O_PC);
    // CSR instruction with an interrupt pending in WB.
    setv(20, I_IR, 3'd1, O_IREQ | O_IRL);
    setv(21, I_CSR, 3'd2, O_0);
    setv(22, I_CSR, 3'd3, O_0);
    setv(23, I_CSR | I_IRQ, 3'd5, O_WREG | O_WCSR | O_PC | O_RET);
    setv(24, I_IRQ, 3'd6, O_TRAP | O_PC);
    // One-cycle fetch stall, then an exception in WB cancels the commit.
    setv(25, I_0, 3'd1, O_IREQ);
    setv(26, I_IR, 3'd1, O_IREQ | O_IRL);
    setv(27, I_0, 3'd2, O_0);
    setv(28, I_0, 3'd3, O_0);
    setv(29, I_EXC, 3'd5, O_0);
    setv(30, I_0, 3'd6, O_TRAP | O_PC);
    // Store faulting in MEM: the request stays up but the write is suppressed.
    setv(31, I_IR, 3'd1, O_IREQ | O_IRL);
    setv(32, I_ST, 3'd2, O_0);
    setv(33, I_ST, 3'd3, O_0);
    setv(34, I_ST | I_EXC, 3'd4, O_DREQ);
    setv(35, I_0, 3'd6, O_TRAP | O_PC);
    // A normal store writes memory but not the regfile.
    setv(36, I_IR, 3'd1, O_IREQ | O_IRL);
    setv(37, I_ST, 3'd2, O_0);
    setv(38, I_ST, 3'd3, O_0);
    setv(39, I_ST | I_DR, 3'd4, O_DREQ | O_DWE);
    setv(40, I_ST, 3'd5, O_PC | O_RET);
    // An exception in FETCH wins over imem_ready.
    setv(41, I_IR | I_EXC, 3'd1, O_IREQ);
    setv(42, I_0, 3'd6, O_TRAP | O_PC);
    setv(43, I_IR, 3'd1, O_IREQ | O_IRL);

    mret      = 1'b0;
    pc_addr   = 64'h0000_0000_8000_1000;
    dmem_addr = 64'h0000_0000_2000_0040;
    rst       = 1'b1;
    {imem_ready, dmem_ready, is_LOAD, is_STORE, is_CSR, exc_en, irq_pending} = I_IR;

    // The outputs must be quiet while reset is held.
    @(negedge clk);
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_outs", 64'(outs_now()), 64'd0);
    $display("reset state=%0d outs=%b", state, outs_now());
    adv();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].in);
      chk($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].st));
      chk($sformatf("vec%0d_outs", i), 64'(outs_now()), 64'(vecs[i].out));
      $display("vec %0d in=%b state=%0d outs=%b", i, vecs[i].in, state, outs_now());
      adv();
    end

    // Store that never completes: timeout on the 16th MEM cycle, code 7.
    apply(I_ST); chk("st_to_decode", 64'(state), 64'd2); adv();
    apply(I_ST); chk("st_to_exec", 64'(state), 64'd3); adv();
    for (int k = 1; k <= 16; k++) begin
      apply(I_ST);
      chk($sformatf("st_to_mem%0d_state", k), 64'(state), 64'd4);
      chk($sformatf("st_to_mem%0d_exc", k), 64'(to_exc_en), 64'(k == 16));
      if (k == 16) begin
        chk("st_to_code", 64'(to_exc_code), 64'd7);
        chk("st_to_val", to_exc_val, dmem_addr);
        chk("st_to_dmem_we", 64'(dmem_we), 64'd1);
      end
      adv();
    end
    apply(I_ST);
    $display("store timeout trap state=%0d outs=%b", state, outs_now());
    chk("st_to_trap_state", 64'(state), 64'd6);
    chk("st_to_trap_outs", 64'(outs_now()), 64'(O_TRAP | O_PC));
    adv();

    // Fetch that never completes: timeout on the 16th FETCH cycle, code 1.
    pc_addr = 64'h0000_0000_8000_2004;
    for (int k = 1; k <= 16; k++) begin
      apply(I_0);
      chk($sformatf("if_to%0d_state", k), 64'(state), 64'd1);
      chk($sformatf("if_to%0d_exc", k), 64'(to_exc_en), 64'(k == 16));
      if (k == 16) begin
        chk("if_to_code", 64'(to_exc_code), 64'd1);
        chk("if_to_val", to_exc_val, pc_addr);
      end
      adv();
    end
    apply(I_0);
    $display("fetch timeout trap state=%0d outs=%b", state, outs_now());
    chk("if_to_trap_state", 64'(state), 64'd6);
    adv();

    // imem_ready arriving exactly at the timeout point is accepted.
    for (int k = 1; k <= 16; k++) begin
      apply((k == 16) ? I_IR : I_0);
      chk($sformatf("if_late%0d_exc", k), 64'(to_exc_en), 64'd0);
      chk($sformatf("if_late%0d_irl", k), 64'(ir_load), 64'(k == 16));
      adv();
    end
    apply(I_LD);
    $display("late fetch accepted state=%0d", state);
    chk("if_late_decode", 64'(state), 64'd2);
    adv();

    // Load that never completes: code 5.
    dmem_addr = 64'h0000_0000_3000_0108;
    apply(I_LD); chk("ld_to_exec", 64'(state), 64'd3); adv();
    for (int k = 1; k <= 16; k++) begin
      apply(I_LD);
      chk($sformatf("ld_to%0d_exc", k), 64'(to_exc_en), 64'(k == 16));
      if (k == 16) begin
        chk("ld_to_code", 64'(to_exc_code), 64'd5);
        chk("ld_to_val", to_exc_val, dmem_addr);
      end
      adv();
    end
    apply(I_0);
    $display("load timeout trap state=%0d outs=%b", state, outs_now());
    chk("ld_to_trap_outs", 64'(outs_now()), 64'(O_TRAP | O_PC));
    adv();

    // Asynchronous reset in the middle of a data request.
    apply(I_IR); chk("rst_fetch", 64'(state), 64'd1); adv();
    apply(I_LD); adv();
    apply(I_LD); adv();
    apply(I_LD);
    chk("rst_pre_dreq", 64'(dmem_req), 64'd1);
    #2 rst = 1'b1;
    #1;
    $display("async reset mid-MEM state=%0d dmem_req=%0d", state, dmem_req);
    chk("rst_async_dreq", 64'(dmem_req), 64'd0);
    chk("rst_async_state", 64'(state), 64'd0);
    adv();
    rst = 1'b0;
    apply(I_IR); chk("rst_idle", 64'(state), 64'd0); adv();
    apply(I_IR); chk("rst_then_fetch", 64'(state), 64'd1);
    adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
